// File: rtl/vga_scan_palette.sv
// 640x480 raster generator with a two-tick colour pipeline: scan position out to the
// sprite renderers, their colorcode back through the game palette to VGA RGB and syncs.
module vga_scan_palette #(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] colorcode,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       pixel_tick,
  output logic       frame_start,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] X_VIS    = 10'(H_VIS);
  localparam logic [9:0] Y_VIS    = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  function automatic logic [23:0] palette(input logic [5:0] code);
    case (code)
      6'd0:    palette = 24'hFFFFFF;
      6'd1:    palette = 24'h000000;
      6'd2:    palette = 24'h27B212;
      6'd3:    palette = 24'hD80222;
      6'd4:    palette = 24'h5DB1F0;
      6'd5:    palette = 24'hF1FF0A;
      6'd6:    palette = 24'hB2B2B0;
      6'd7:    palette = 24'hF27A00;
      6'd8:    palette = 24'h663300;
      default: palette = 24'h000000;
    endcase
  endfunction

  logic [DIV_W-1:0] div;
  logic             hs_raw;
  logic             vs_raw;
  logic             vis_raw;
  logic [5:0]       s1_code;
  logic             s1_hs;
  logic             s1_vs;
  logic             s1_vis;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      div <= '0;
    else if (div == DIV_LAST)
      div <= '0;
    else
      div <= div + 1'b1;
  end

  // Gated by Reset so a divide-by-one build still shows no tick while held in reset.
  assign pixel_tick  = (div == DIV_LAST) && !Reset;
  assign frame_start = pixel_tick && (DrawX == 10'd0) && (DrawY == 10'd0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      DrawX <= '0;
      DrawY <= '0;
    end else if (pixel_tick) begin
      if (DrawX == X_LAST) begin
        DrawX <= '0;
        DrawY <= (DrawY == Y_LAST) ? 10'd0 : DrawY + 10'd1;
      end else begin
        DrawX <= DrawX + 10'd1;
      end
    end
  end

  always_comb begin
    hs_raw  = !((DrawX >= HS_START) && (DrawX < HS_END));
    vs_raw  = !((DrawY >= VS_START) && (DrawY < VS_END));
    vis_raw = (DrawX < X_VIS) && (DrawY < Y_VIS);
  end

  // Syncs and blank travel alongside the colour so all VGA outputs share one latency.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_code     <= '0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      s1_vis      <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else if (pixel_tick) begin
      s1_code     <= colorcode;
      s1_hs       <= hs_raw;
      s1_vs       <= vs_raw;
      s1_vis      <= vis_raw;
      VGA_HS      <= s1_hs;
      VGA_VS      <= s1_vs;
      VGA_BLANK_N <= s1_vis;
      {VGA_R, VGA_G, VGA_B} <= s1_vis ? palette(s1_code) : 24'h000000;
    end
  end

endmodule

// File: tb/tb_vga_scan_palette.sv
// Bench for vga_scan_palette: full-size instance for reset, line timing, palette and
// mid-frame reset; a shrunken-geometry instance for multi-frame wrap and vertical sync.
module tb_vga_scan_palette;

  typedef struct {
    int divn; int hvis; int hfp; int hsync; int htot;
    int vvis; int vfp; int vsync; int vtot;
  } geom_t;

  typedef struct { int x; int y; logic [5:0] code; } pix_t;

  typedef struct { int x; int y; logic [5:0] code; logic [23:0] rgb; logic blank; } vec_t;

  logic       clk = 1'b0;
  logic       rst [2];
  logic [5:0] code [2];
  logic [9:0] dx [2];
  logic [9:0] dy [2];
  logic       pt [2];
  logic       fs [2];
  logic       hs [2];
  logic       vs [2];
  logic       bl [2];
  logic [7:0] r [2];
  logic [7:0] g [2];
  logic [7:0] b [2];

  geom_t       geo [2];
  int          mt [2];
  pix_t        p1 [2];
  pix_t        p2 [2];
  logic [23:0] pal_tab [9];
  vec_t        tbl [12];

  int nchk = 0;
  int nerr = 0;
  int first_hs, hs_low, blank_run, blank_max, fs_cnt, vs_low;

  always #5 clk = ~clk;

  vga_scan_palette dut (
    .Clk(clk), .Reset(rst[0]), .colorcode(code[0]), .DrawX(dx[0]), .DrawY(dy[0]),
    .pixel_tick(pt[0]), .frame_start(fs[0]), .VGA_HS(hs[0]), .VGA_VS(vs[0]),
    .VGA_BLANK_N(bl[0]), .VGA_R(r[0]), .VGA_G(g[0]), .VGA_B(b[0])
  );

  vga_scan_palette #(
    .CLK_DIV(3), .H_VIS(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_s (
    .Clk(clk), .Reset(rst[1]), .colorcode(code[1]), .DrawX(dx[1]), .DrawY(dy[1]),
    .pixel_tick(pt[1]), .frame_start(fs[1]), .VGA_HS(hs[1]), .VGA_VS(vs[1]),
    .VGA_BLANK_N(bl[1]), .VGA_R(r[1]), .VGA_G(g[1]), .VGA_B(b[1])
  );

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] want);
    nchk++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %0d.%s: got %0h, expected %0h at time %0t", i, nm, act, want, $time);
    end
  endtask

  function automatic logic [5:0] rnd_code();
    if ($urandom_range(0, 3) == 0) return 6'($urandom_range(9, 63));
    return 6'($urandom_range(0, 8));
  endfunction

  function automatic logic [23:0] pal_m(input logic [5:0] c);
    return (c < 6'd9) ? pal_tab[c] : 24'h000000;
  endfunction

  function automatic int pos_x(input int i, input int t);
    return t % geo[i].htot;
  endfunction

  function automatic int pos_y(input int i, input int t);
    return (t / geo[i].htot) % geo[i].vtot;
  endfunction

  // One pixel tick: check tick spacing, presented position and the delayed outputs,
  // then supply the renderer colour for the presented pixel.
  task automatic step(input int i, input logic [5:0] c);
    int n;
    int x;
    int y;
    logic e_hs, e_vs, e_vis;
    logic [23:0] e_rgb;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pt[i] && n < 20);
    chk("tick_gap", i, 32'(n), 32'(geo[i].divn));
    x = pos_x(i, mt[i]);
    y = pos_y(i, mt[i]);
    chk("draw_x", i, 32'(dx[i]), x);
    chk("draw_y", i, 32'(dy[i]), y);
    chk("frame_start", i, 32'(fs[i]), 32'(x == 0 && y == 0));
    if (mt[i] >= 2) begin
      e_hs  = !(p2[i].x >= geo[i].hvis + geo[i].hfp && p2[i].x < geo[i].hvis + geo[i].hfp + geo[i].hsync);
      e_vs  = !(p2[i].y >= geo[i].vvis + geo[i].vfp && p2[i].y < geo[i].vvis + geo[i].vfp + geo[i].vsync);
      e_vis = (p2[i].x < geo[i].hvis) && (p2[i].y < geo[i].vvis);
      e_rgb = e_vis ? pal_m(p2[i].code) : 24'h000000;
    end else begin
      e_hs = 1'b1; e_vs = 1'b1; e_vis = 1'b0; e_rgb = 24'h000000;
    end
    chk("hs", i, 32'(hs[i]), 32'(e_hs));
    chk("vs", i, 32'(vs[i]), 32'(e_vs));
    chk("blank_n", i, 32'(bl[i]), 32'(e_vis));
    chk("rgb", i, 32'({r[i], g[i], b[i]}), 32'(e_rgb));
    code[i] = c;
    p2[i] = p1[i];
    p1[i] = '{x, y, c};
    mt[i]++;
  endtask

  task automatic advance(input int i, input int tx, input int ty);
    while (!(pos_x(i, mt[i]) == tx && pos_y(i, mt[i]) == ty)) step(i, rnd_code());
  endtask

  task automatic check_reset_vals(input int i, input string tag);
    chk({tag, "_x"}, i, 32'(dx[i]), 0);
    chk({tag, "_y"}, i, 32'(dy[i]), 0);
    chk({tag, "_hs"}, i, 32'(hs[i]), 1);
    chk({tag, "_vs"}, i, 32'(vs[i]), 1);
    chk({tag, "_blank"}, i, 32'(bl[i]), 0);
    chk({tag, "_rgb"}, i, 32'({r[i], g[i], b[i]}), 0);
    chk({tag, "_tick"}, i, 32'(pt[i]), 0);
    chk({tag, "_fs"}, i, 32'(fs[i]), 0);
  endtask

  task automatic release_rst(input int i);
    @(posedge clk);
    #1 rst[i] = 1'b0;
    mt[i] = 0;
  endtask

  initial begin
    geo[0] = '{2, 640, 16, 96, 800, 480, 10, 2, 525};
    geo[1] = '{3, 12, 2, 3, 20, 6, 2, 2, 12};
    pal_tab = '{24'hFFFFFF, 24'h000000, 24'h27B212, 24'hD80222, 24'h5DB1F0,
                24'hF1FF0A, 24'hB2B2B0, 24'hF27A00, 24'h663300};
    tbl = '{
      '{10, 5, 6'd3,  24'hD80222, 1'b1},
      '{14, 5, 6'd6,  24'hB2B2B0, 1'b1},
      '{18, 5, 6'd9,  24'h000000, 1'b1},
      '{22, 5, 6'd63, 24'h000000, 1'b1},
      '{26, 5, 6'd0,  24'hFFFFFF, 1'b1},
      '{700, 5, 6'd0, 24'h000000, 1'b0},
      '{20, 6, 6'd2,  24'h27B212, 1'b1},
      '{24, 6, 6'd4,  24'h5DB1F0, 1'b1},
      '{28, 6, 6'd5,  24'hF1FF0A, 1'b1},
      '{32, 6, 6'd7,  24'hF27A00, 1'b1},
      '{36, 6, 6'd8,  24'h663300, 1'b1},
      '{40, 6, 6'd1,  24'h000000, 1'b1}
    };
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; code[i] = '0; mt[i] = 0;
      p1[i] = '{0, 0, 6'd0}; p2[i] = '{0, 0, 6'd0};
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_vals(0, "reset");
    $display("reset held 5 cycles, reset values checked");

    release_rst(0);
    first_hs = -1; hs_low = 0; blank_run = 0; blank_max = 0;
    for (int t = 0; t < 2400; t++) begin
      step(0, rnd_code());
      if (!hs[0] && first_hs < 0) first_hs = t;
      if (t >= 800 && t < 1600) begin
        if (!hs[0]) hs_low++;
        if (bl[0]) begin
          blank_run++;
          if (blank_run > blank_max) blank_max = blank_run;
        end else begin
          blank_run = 0;
        end
      end
    end
    chk("hs_first_fall", 0, first_hs, 658);
    chk("hs_low_ticks", 0, hs_low, 96);
    chk("blank_run", 0, blank_max, 640);
    $display("line timing: hs fall at tick %0d, hs low %0d, blank run %0d", first_hs, hs_low, blank_max);

    for (int k = 0; k < 12; k++) begin
      advance(0, tbl[k].x, tbl[k].y);
      step(0, tbl[k].code);
      step(0, rnd_code());
      step(0, rnd_code());
      chk("vec_rgb", 0, 32'({r[0], g[0], b[0]}), 32'(tbl[k].rgb));
      chk("vec_blank", 0, 32'(bl[0]), 32'(tbl[k].blank));
      $display("vector %0d: (%0d,%0d) code %0d -> rgb %06h blank_n %0b",
               k, tbl[k].x, tbl[k].y, tbl[k].code, {r[0], g[0], b[0]}, bl[0]);
    end

    advance(0, 300, 20);
    step(0, rnd_code());
    #1 rst[0] = 1'b1;
    #1 check_reset_vals(0, "async_rst");
    repeat (3) @(posedge clk);
    release_rst(0);
    for (int t = 0; t < 6; t++) step(0, rnd_code());
    $display("mid-frame reset at (300,20): scan restarted from (0,0)");
    rst[0] = 1'b1;

    release_rst(1);
    fs_cnt = 0; vs_low = 0;
    for (int t = 0; t < 721; t++) begin
      step(1, rnd_code());
      if (fs[1]) fs_cnt++;
      if (t >= 240 && t < 480 && !vs[1]) vs_low++;
    end
    chk("frame_starts", 1, fs_cnt, 4);
    chk("vs_low_ticks", 1, vs_low, 40);
    $display("small geometry: %0d frame starts, vs low %0d ticks per frame", fs_cnt, vs_low);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
